// File: rtl/full_mas_serdes_pkg.sv
// Shared definitions for the full_mas serial link.
// The receive-side deserializers use the same lane widths and line levels.
//   LANE0_W / LANE1_W : bits carried on lane 0 / lane 1 per frame
//   DATA_W            : full word width (lane 0 field in the LSBs)
//   START_BIT         : level of the frame start bit on both lanes
//   IDLE_BIT          : level driven on a lane with nothing to send
//   state_e           : transmit FSM states
package full_mas_serdes_pkg;

    localparam int   LANE0_W   = 5;
    localparam int   LANE1_W   = 32;
    localparam int   DATA_W    = LANE0_W + LANE1_W;
    localparam logic START_BIT = 1'b1;
    localparam logic IDLE_BIT  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/serializer_nbit.sv
// One serial lane: a shift register with start-bit insertion.
//   clk    : clock
//   reset  : asynchronous active-low reset
//   load   : capture data and drive the start bit on the next cycle
//   shift  : drive the next data bit (LSB first), or idle once all
//            WIDTH bits have been sent
//   data   : word to send
//   serial : registered lane output
// The lane idles by itself after WIDTH data bits, so a narrow lane can
// share the shift strobe of a wider one.
module serializer_nbit
    import full_mas_serdes_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             serial
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    left;   // data bits still to be driven

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg   <= '0;
            left   <= '0;
            serial <= IDLE_BIT;
        end else if (load) begin
            sreg   <= data;
            left   <= FULL;
            serial <= START_BIT;
        end else if (shift && (left != '0)) begin
            serial <= sreg[0];
            sreg   <= sreg >> 1;
            left   <= left - CW'(1);
        end else begin
            serial <= IDLE_BIT;
        end
    end

endmodule

// File: rtl/full_mas_serializer.sv
// Transmit-side master serializer. Accepts one DATA_W-bit word per frame
// over valid/ready and sends it on two start-bit framed serial lanes,
// followed by GAP idle cycles.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   data_i    : word; [4:0] goes to lane 0, [36:5] to lane 1
//   valid_i   : data_i is valid
//   ready_o   : word accepted on a clock edge where valid_i && ready_o
//   serial_o  : [0] lane 0, [1] lane 1 (registered)
//   busy_o    : frame or gap in progress (inverse of ready_o)
//   dbg_state : current FSM state
// Handshake: a transfer happens on every rising clk edge where valid_i
// and ready_o are both 1; ready_o depends only on registered state and
// reset, and inputs are ignored while ready_o is 0.
module full_mas_serializer
    import full_mas_serdes_pkg::*;
#(
    parameter int GAP = 2   // idle cycles after the last lane-1 bit, 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [1:0]        serial_o,
    output logic              busy_o,
    output state_e            dbg_state
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);
    localparam logic [4:0] LAST_BIT = 5'(LANE1_W - 1);

    state_e     state;
    logic [4:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic       accept;
    logic       shift_en;

    // ready_o is forced low while reset is held.
    assign ready_o   = reset && (state == ST_IDLE);
    assign busy_o    = !ready_o;
    assign accept    = valid_i && ready_o;
    // START drives the first data bit out, SHIFT the rest.
    assign shift_en  = (state == ST_START) || (state == ST_SHIFT);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_START;
                end
                ST_START: begin
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    serializer_nbit #(.WIDTH(LANE0_W)) u_lane0 (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .shift  (shift_en),
        .data   (data_i[LANE0_W-1:0]),
        .serial (serial_o[0])
    );

    serializer_nbit #(.WIDTH(LANE1_W)) u_lane1 (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .shift  (shift_en),
        .data   (data_i[DATA_W-1:LANE0_W]),
        .serial (serial_o[1])
    );

endmodule
